noc_receiver: RTL and testbench
===============================

Name: noc_receiver

Overview:
- Link-side receive stage. Consumes the flat packet word assembled by the NoC packet-assembly stage, checks destination and valid bits, and re-pairs split RESPONSE_ADDR/RESPONSE_DATA packets into one address+data record.
- Buffers records in a small FIFO and presents them to the local core over valid/ready.
- Generates the link-level send-ok (credit) bit returned to the upstream sender.

Parameters:
MY_ID, 0, node address compared against the packet dest field (width `DESTWIDTH).
FIFO_DEPTH, 4, record FIFO entries; power of two, >= 4.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous, active-high reset.
pkt_in  in  `IO_WIDTH  packet word. Fields MSB→LSB: sendokbit, sendbit, nhop, lastbit, dest, src, type, data, addr.
ok_out  out  1  send-ok to the upstream sender; upstream may launch a packet in the cycle after it samples 1.
rec_valid  out  1  record available.
rec_ready  in  1  core accepts the record.
rec_type  out  `DATA_TYPEWIDTH  record type.
rec_src  out  `DATA_SRCWIDTH  source node.
rec_addr  out  `DATA_AWIDTH  address.
rec_data  out  `DATA_DWIDTH  data.
rec_last  out  1  lastbit of the final packet of the record.
overflow  out  1  sticky: an accepted packet found the FIFO full.
proto_err  out  1  sticky: pairing violation.

Behaviour:
- Accept condition: pkt_in.sendbit==1 and dest==MY_ID. All other words are ignored with no state change. The nhop and sendokbit fields of pkt_in are ignored.
- Type codes: REQUEST=0, RESPONSE_ADDR=1, RESPONSE_DATA=2, C_REQ=3, WRITE=4, OUTSTANDING=5. Codes 6..127 are accepted and passed through like REQUEST.
- Pairing FSM, states IDLE and HAVE_ADDR. Pending registers: p_addr, p_src.
  - IDLE + RESPONSE_ADDR: latch addr field and src → HAVE_ADDR. No push.
  - HAVE_ADDR + RESPONSE_DATA with src==p_src: push {type=2, src, addr=p_addr, data=data field, last=lastbit} → IDLE.
  - HAVE_ADDR + RESPONSE_DATA with src!=p_src: set proto_err, discard packet and pending addr → IDLE.
  - HAVE_ADDR + RESPONSE_ADDR: set proto_err, overwrite p_addr/p_src, stay in HAVE_ADDR.
  - IDLE + RESPONSE_DATA: set proto_err, drop packet.
  - Any other type, either state: push {type, src, addr, data, lastbit} immediately. The FSM state is unchanged, so a pending addr survives interleaved non-response packets.
- Push timing: a push requested in cycle t is written at the clk edge ending cycle t. rec_valid rises in t+1 (one-cycle latency). There is no bypass path.
- FIFO full at push time: record dropped, overflow set, FSM still transitions as above.
- Simultaneous push and pop when full: pop frees the slot, push succeeds, overflow not set.
- rec_* fields are held stable while rec_valid=1 and rec_ready=0.
- ok_out is registered: ok_out(t+1) = (occupancy after the cycle-t update) <= FIFO_DEPTH-2. This gives one slot of slack for a packet launched on a stale ok.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Reset (synchronous, any cycle, including mid-pair): state=IDLE, FIFO empty, rec_valid=0, rec_* fields=0, overflow=0, proto_err=0, ok_out=1. A packet on pkt_in during the reset cycle is discarded.

Decomposition:
- noc_pkt.vh gains:
  - field LSB-offset macros (ADDR_LSB, DATA_LSB, TYPE_LSB, SRC_LSB, DEST_LSB, LAST_BIT, NHOP_LSB, SEND_BIT, SENDOK_BIT);
  - TYPE_* code macros;
  - REC_WIDTH = TYPE+SRC+A+D+1.
- One sub-module: noc_sync_fifo (parameters WIDTH, DEPTH). Ports: push, din, full, pop, dout, empty, count. It is reusable by the transmit side.

Test Plan:
1. dest=MY_ID, RESPONSE_ADDR addr=0x100 src=3, then RESPONSE_DATA data=0xDEADBEEF src=3 last=1 → exactly one record {2,3,0x100,0xDEADBEEF,1}, rec_valid high the cycle after the DATA packet, proto_err=0.
2. WRITE packets with dest=MY_ID+1 and with sendbit=0 → no record, ok_out stays 1. Same packet with dest=MY_ID → record pushed unchanged.
3. FIFO_DEPTH=4, rec_ready=0, four REQUEST packets back to back → ok_out falls to 0 one cycle after 3rd push. 5th packet → overflow=1, 4 records retained in order. Drain → ok_out returns to 1.
4. RESPONSE_DATA in IDLE → proto_err=1, no record. ADDR(src=1) then DATA(src=2) → proto_err, no record, FSM back to IDLE (next ADDR/DATA pair pairs correctly).
5. ADDR 0x20, then C_REQ, then DATA 0x55 (same src) → C_REQ record first, then paired record {2, addr 0x20, data 0x55}.
6. Assert rst between ADDR and DATA → after reset: no record from the orphan DATA beyond proto_err=1; outputs at reset values listed above.

Source files
------------

// File: rtl/noc_receiver_pkg.sv
// Shared field layout, type codes and record format for the NoC receive path.
package noc_receiver_pkg;

    // Field widths of the flat packet word.
    localparam int DATA_AWIDTH    = 16;
    localparam int DATA_DWIDTH    = 32;
    localparam int DATA_TYPEWIDTH = 7;
    localparam int DATA_SRCWIDTH  = 4;
    localparam int DESTWIDTH      = 4;
    localparam int NHOPWIDTH      = 4;

    // LSB offsets of each field, packed MSB->LSB as sendok, send, nhop, last, dest, src, type, data, addr.
    localparam int ADDR_LSB   = 0;
    localparam int DATA_LSB   = ADDR_LSB + DATA_AWIDTH;
    localparam int TYPE_LSB   = DATA_LSB + DATA_DWIDTH;
    localparam int SRC_LSB    = TYPE_LSB + DATA_TYPEWIDTH;
    localparam int DEST_LSB   = SRC_LSB + DATA_SRCWIDTH;
    localparam int LAST_BIT   = DEST_LSB + DESTWIDTH;
    localparam int NHOP_LSB   = LAST_BIT + 1;
    localparam int SEND_BIT   = NHOP_LSB + NHOPWIDTH;
    localparam int SENDOK_BIT = SEND_BIT + 1;
    localparam int IO_WIDTH   = SENDOK_BIT + 1;

    // Packet type codes; anything not listed travels like a REQUEST.
    localparam logic [DATA_TYPEWIDTH-1:0] TYPE_REQUEST       = 7'd0;
    localparam logic [DATA_TYPEWIDTH-1:0] TYPE_RESPONSE_ADDR = 7'd1;
    localparam logic [DATA_TYPEWIDTH-1:0] TYPE_RESPONSE_DATA = 7'd2;
    localparam logic [DATA_TYPEWIDTH-1:0] TYPE_C_REQ         = 7'd3;
    localparam logic [DATA_TYPEWIDTH-1:0] TYPE_WRITE         = 7'd4;
    localparam logic [DATA_TYPEWIDTH-1:0] TYPE_OUTSTANDING   = 7'd5;

    localparam int REC_WIDTH = DATA_TYPEWIDTH + DATA_SRCWIDTH + DATA_AWIDTH + DATA_DWIDTH + 1;

    typedef struct packed {
        logic                      sendok;
        logic                      send;
        logic [NHOPWIDTH-1:0]      nhop;
        logic                      last;
        logic [DESTWIDTH-1:0]      dest;
        logic [DATA_SRCWIDTH-1:0]  src;
        logic [DATA_TYPEWIDTH-1:0] ptype;
        logic [DATA_DWIDTH-1:0]    data;
        logic [DATA_AWIDTH-1:0]    addr;
    } pkt_t;

    typedef struct packed {
        logic [DATA_TYPEWIDTH-1:0] rtype;
        logic [DATA_SRCWIDTH-1:0]  src;
        logic [DATA_AWIDTH-1:0]    addr;
        logic [DATA_DWIDTH-1:0]    data;
        logic                      last;
    } rec_t;

    typedef enum logic {
        ST_IDLE,
        ST_HAVE_ADDR
    } pair_state_t;

endpackage

// File: rtl/noc_receiver_if.sv
// Link-side packet input plus the record valid/ready channel toward the local core.
interface noc_receiver_if;
    import noc_receiver_pkg::*;

    logic [IO_WIDTH-1:0]       pkt_in;
    logic                      ok_out;
    logic                      rec_valid;
    logic                      rec_ready;
    logic [DATA_TYPEWIDTH-1:0] rec_type;
    logic [DATA_SRCWIDTH-1:0]  rec_src;
    logic [DATA_AWIDTH-1:0]    rec_addr;
    logic [DATA_DWIDTH-1:0]    rec_data;
    logic                      rec_last;

    modport master (
        output pkt_in, rec_ready,
        input  ok_out, rec_valid, rec_type, rec_src, rec_addr, rec_data, rec_last
    );

    modport slave (
        input  pkt_in, rec_ready,
        output ok_out, rec_valid, rec_type, rec_src, rec_addr, rec_data, rec_last
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module noc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en) && !rst;
    assign dout  = mem[rd_ptr];

    // Storage is not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/noc_receiver.sv
// Receive stage: filters packets for this node, re-pairs split responses, queues records, returns credit.
module noc_receiver
    import noc_receiver_pkg::*;
#(
    parameter logic [DESTWIDTH-1:0] MY_ID      = '0,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    noc_receiver_if.slave  bus,
    output logic           overflow,
    output logic           proto_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pkt_t                     pkt;
    logic                     accept;
    pair_state_t              state;
    logic [DATA_AWIDTH-1:0]   p_addr;
    logic [DATA_SRCWIDTH-1:0] p_src;
    logic                     push_req;
    rec_t                     push_rec;
    logic [REC_WIDTH-1:0]     head_bits;
    rec_t                     head;
    logic                     full;
    logic                     empty;
    logic                     pop;
    logic                     push_ok;
    logic [CW-1:0]            count;
    logic [CW-1:0]            next_count;
    logic                     ok_q;

    assign pkt        = pkt_t'(bus.pkt_in);
    assign accept     = pkt.send && (pkt.dest == MY_ID);
    assign pop        = bus.rec_ready && !empty;
    assign push_ok    = push_req && (!full || pop);
    assign next_count = count + CW'(push_ok) - CW'(pop);
    assign head       = rec_t'(head_bits);

    // Decide whether this cycle's packet produces a record and what it contains.
    always_comb begin
        push_req = 1'b0;
        push_rec = '0;
        if (accept) begin
            if (pkt.ptype == TYPE_RESPONSE_DATA) begin
                if (state == ST_HAVE_ADDR && pkt.src == p_src) begin
                    push_req = 1'b1;
                    push_rec = '{rtype: TYPE_RESPONSE_DATA, src: pkt.src, addr: p_addr,
                                 data: pkt.data, last: pkt.last};
                end
            end else if (pkt.ptype != TYPE_RESPONSE_ADDR) begin
                push_req = 1'b1;
                push_rec = '{rtype: pkt.ptype, src: pkt.src, addr: pkt.addr,
                             data: pkt.data, last: pkt.last};
            end
        end
    end

    // Pairing FSM, sticky error flags and the registered credit bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            p_addr    <= '0;
            p_src     <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
            ok_q      <= 1'b1;
        end else begin
            ok_q <= (next_count <= CW'(FIFO_DEPTH - 2));
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                case (pkt.ptype)
                    TYPE_RESPONSE_ADDR: begin
                        if (state == ST_HAVE_ADDR) begin
                            proto_err <= 1'b1;
                        end
                        p_addr <= pkt.addr;
                        p_src  <= pkt.src;
                        state  <= ST_HAVE_ADDR;
                    end
                    TYPE_RESPONSE_DATA: begin
                        if (state == ST_IDLE || pkt.src != p_src) begin
                            proto_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    noc_sync_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (push_rec),
        .full  (full),
        .pop   (pop),
        .dout  (head_bits),
        .empty (empty),
        .count (count)
    );

    assign bus.ok_out    = ok_q;
    assign bus.rec_valid = !empty;
    assign bus.rec_type  = empty ? '0 : head.rtype;
    assign bus.rec_src   = empty ? '0 : head.src;
    assign bus.rec_addr  = empty ? '0 : head.addr;
    assign bus.rec_data  = empty ? '0 : head.data;
    assign bus.rec_last  = empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_noc_receiver.sv
// Directed bench for noc_receiver: vector table plus hand-written overflow and reset sequences.
module tb_noc_receiver;
    import noc_receiver_pkg::*;

    localparam logic [DESTWIDTH-1:0] ME    = 4'd5;
    localparam int                   DEPTH = 4;

    typedef struct packed {
        logic                      valid;
        logic [DATA_TYPEWIDTH-1:0] rtype;
        logic [DATA_SRCWIDTH-1:0]  src;
        logic [DATA_AWIDTH-1:0]    addr;
        logic [DATA_DWIDTH-1:0]    data;
        logic                      last;
        logic                      ok;
        logic                      ovf;
        logic                      err;
    } exp_t;

    typedef struct {
        string               name;
        logic [IO_WIDTH-1:0] pkt;
        logic                ready;
        exp_t                exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic overflow;
    logic proto_err;
    int   cmpCount = 0;
    int   errCount = 0;
    vec_t vecs[$];

    noc_receiver_if bus ();

    noc_receiver #(
        .MY_ID      (ME),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [IO_WIDTH-1:0] mkPkt(input logic send, input logic [3:0] dest,
                                                  input logic [6:0] ptype, input logic [3:0] src,
                                                  input logic [15:0] addr, input logic [31:0] data,
                                                  input logic last);
        pkt_t p;
        p.sendok = 1'b1;
        p.send   = send;
        p.nhop   = 4'hA;
        p.last   = last;
        p.dest   = dest;
        p.src    = src;
        p.ptype  = ptype;
        p.data   = data;
        p.addr   = addr;
        return p;
    endfunction

    function automatic exp_t mkExp(input logic valid, input logic [6:0] rtype, input logic [3:0] src,
                                   input logic [15:0] addr, input logic [31:0] data, input logic last,
                                   input logic ok, input logic ovf, input logic err);
        exp_t e;
        e = '{valid, rtype, src, addr, data, last, ok, ovf, err};
        return e;
    endfunction

    function automatic exp_t noRec(input logic ok, input logic ovf, input logic err);
        return mkExp(1'b0, 7'd0, 4'd0, 16'd0, 32'd0, 1'b0, ok, ovf, err);
    endfunction

    function automatic vec_t mkVec(input string name, input logic [IO_WIDTH-1:0] pkt,
                                   input logic ready, input exp_t exp);
        vec_t v;
        v.name  = name;
        v.pkt   = pkt;
        v.ready = ready;
        v.exp   = exp;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the clock edge that consumed them.
    task automatic applyStimulus(input logic [IO_WIDTH-1:0] pkt, input logic ready);
        bus.pkt_in    = pkt;
        bus.rec_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [IO_WIDTH-1:0] pkt);
        rst = 1'b1;
        applyStimulus(pkt, 1'b0);
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        exp_t a;
        a = '{bus.rec_valid, bus.rec_type, bus.rec_src, bus.rec_addr, bus.rec_data,
              bus.rec_last, bus.ok_out, overflow, proto_err};
        cmpCount++;
        if (a !== e) begin
            errCount++;
            $display("[TB] FAIL %s: got v=%b t=%0d s=%0d a=%h d=%h l=%b ok=%b ovf=%b err=%b, want v=%b t=%0d s=%0d a=%h d=%h l=%b ok=%b ovf=%b err=%b",
                     name, a.valid, a.rtype, a.src, a.addr, a.data, a.last, a.ok, a.ovf, a.err,
                     e.valid, e.rtype, e.src, e.addr, e.data, e.last, e.ok, e.ovf, e.err);
        end
    endtask

    initial begin
        logic [IO_WIDTH-1:0] idle;
        idle          = mkPkt(1'b0, ME, 7'd0, 4'd0, 16'd0, 32'd0, 1'b0);
        bus.pkt_in    = idle;
        bus.rec_ready = 1'b0;
        rst           = 1'b1;
        applyStimulus(idle, 1'b0);
        doReset(idle);
        checkOutput("reset_values", noRec(1'b1, 1'b0, 1'b0));

        vecs.push_back(mkVec("pair_addr", mkPkt(1, ME, TYPE_RESPONSE_ADDR, 3, 16'h0100, 32'h0, 0), 0,
                             noRec(1, 0, 0)));
        vecs.push_back(mkVec("pair_data", mkPkt(1, ME, TYPE_RESPONSE_DATA, 3, 16'h0999, 32'hDEADBEEF, 1), 0,
                             mkExp(1, 7'd2, 3, 16'h0100, 32'hDEADBEEF, 1, 1, 0, 0)));
        vecs.push_back(mkVec("pair_drain", idle, 1, noRec(1, 0, 0)));
        vecs.push_back(mkVec("wrong_dest", mkPkt(1, ME + 4'd1, TYPE_WRITE, 2, 16'h0044, 32'h1234, 1), 0,
                             noRec(1, 0, 0)));
        vecs.push_back(mkVec("no_sendbit", mkPkt(0, ME, TYPE_WRITE, 2, 16'h0044, 32'h1234, 1), 0,
                             noRec(1, 0, 0)));
        vecs.push_back(mkVec("write_ok", mkPkt(1, ME, TYPE_WRITE, 2, 16'h0044, 32'h1234, 1), 0,
                             mkExp(1, 7'd4, 2, 16'h0044, 32'h1234, 1, 1, 0, 0)));
        vecs.push_back(mkVec("write_drain", idle, 1, noRec(1, 0, 0)));
        vecs.push_back(mkVec("data_in_idle", mkPkt(1, ME, TYPE_RESPONSE_DATA, 1, 16'h0, 32'h11, 0), 0,
                             noRec(1, 0, 1)));
        vecs.push_back(mkVec("addr_src1", mkPkt(1, ME, TYPE_RESPONSE_ADDR, 1, 16'h0010, 32'h0, 0), 0,
                             noRec(1, 0, 1)));
        vecs.push_back(mkVec("data_src2", mkPkt(1, ME, TYPE_RESPONSE_DATA, 2, 16'h0, 32'h22, 0), 0,
                             noRec(1, 0, 1)));
        vecs.push_back(mkVec("addr_0x20", mkPkt(1, ME, TYPE_RESPONSE_ADDR, 4, 16'h0020, 32'h0, 0), 0,
                             noRec(1, 0, 1)));
        vecs.push_back(mkVec("creq_between", mkPkt(1, ME, TYPE_C_REQ, 7, 16'h0033, 32'h77, 0), 0,
                             mkExp(1, 7'd3, 7, 16'h0033, 32'h77, 0, 1, 0, 1)));
        vecs.push_back(mkVec("data_0x55", mkPkt(1, ME, TYPE_RESPONSE_DATA, 4, 16'h0, 32'h55, 1), 1,
                             mkExp(1, 7'd2, 4, 16'h0020, 32'h55, 1, 1, 0, 1)));
        vecs.push_back(mkVec("pair2_drain", idle, 1, noRec(1, 0, 1)));
        vecs.push_back(mkVec("type100", mkPkt(1, ME, 7'd100, 1, 16'h0001, 32'h2, 0), 0,
                             mkExp(1, 7'd100, 1, 16'h0001, 32'h2, 0, 1, 0, 1)));
        vecs.push_back(mkVec("type100_drain", idle, 1, noRec(1, 0, 1)));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pkt, vecs[i].ready);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Fill the FIFO with the core stalled, overflow it, then drain in order.
        doReset(idle);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkPkt(1, ME, TYPE_REQUEST, 1, 16'(i), 32'(i + 1), 0), 0);
            checkOutput($sformatf("fill_%0d", i),
                        mkExp(1, 7'd0, 1, 16'd0, 32'd1, 0, (i + 1) <= 2, 0, 0));
        end
        applyStimulus(mkPkt(1, ME, TYPE_REQUEST, 1, 16'd4, 32'd5, 0), 0);
        checkOutput("overflow_push", mkExp(1, 7'd0, 1, 16'd0, 32'd1, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_%0d", i),
                        mkExp(1, 7'd0, 1, 16'(i), 32'(i + 1), 0, (4 - i) <= 2, 1, 0));
            applyStimulus(idle, 1);
        end
        checkOutput("drained", noRec(1, 1, 0));

        // Push and pop together while full: the push must land without overflow.
        doReset(idle);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkPkt(1, ME, TYPE_REQUEST, 1, 16'(i), 32'(i + 1), 0), 0);
        end
        applyStimulus(mkPkt(1, ME, TYPE_REQUEST, 1, 16'd9, 32'd9, 0), 1);
        checkOutput("full_push_pop", mkExp(1, 7'd0, 1, 16'd1, 32'd2, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            logic [15:0] ea;
            ea = (i == 3) ? 16'd9 : 16'(i + 1);
            checkOutput($sformatf("pp_drain_%0d", i),
                        mkExp(1, 7'd0, 1, ea, 32'(ea + ((i == 3) ? 16'd0 : 16'd1)), 0,
                              (4 - i) <= 2, 0, 0));
            applyStimulus(idle, 1);
        end
        checkOutput("pp_drained", noRec(1, 0, 0));

        // Reset mid-pair with a queued record and a set error flag.
        doReset(idle);
        applyStimulus(mkPkt(1, ME, TYPE_RESPONSE_DATA, 6, 16'h0, 32'h0, 0), 0);
        applyStimulus(mkPkt(1, ME, TYPE_REQUEST, 2, 16'h0abc, 32'h0def, 1), 0);
        applyStimulus(mkPkt(1, ME, TYPE_RESPONSE_ADDR, 3, 16'h0100, 32'h0, 0), 0);
        checkOutput("pre_reset", mkExp(1, 7'd0, 2, 16'h0abc, 32'h0def, 1, 1, 0, 1));
        doReset(mkPkt(1, ME, TYPE_RESPONSE_DATA, 3, 16'h0, 32'hCAFE, 1));
        checkOutput("mid_pair_reset", noRec(1, 0, 0));
        applyStimulus(mkPkt(1, ME, TYPE_RESPONSE_DATA, 3, 16'h0, 32'hCAFE, 1), 0);
        checkOutput("orphan_data", noRec(1, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
